inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage of the pipelined RV32 core.
- Owns the PC and drives the instruction-cache read handshake.
- Holds one instruction in a one-entry skid buffer when decode is stalled.
- Drives the IF/ID register whose instruction field feeds decode and the immediate generator; honours decode stalls and branch/jump redirects from EX.

Parameters:
- XLEN, 32, width of PC and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_read  out  1  cache read request.
- ic_addr  out  XLEN  byte address of request; stable while ic_read=1 and ic_stall=1.
- ic_stall  in  1  cache busy; request completes in a cycle with ic_read=1 and ic_stall=0.
- ic_rdata  in  XLEN  instruction; valid only in the completion cycle.
- id_stall  in  1  decode cannot accept; IF/ID must hold.
- redirect_valid  in  1  taken branch or jump resolved in EX.
- redirect_pc  in  XLEN  target address; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  IF/ID holds a live instruction.
- if_pc  out  XLEN  PC of the IF/ID instruction.
- if_pc_plus4  out  XLEN  if_pc+4; used for jal/jalr link.
- if_instr  out  XLEN  instruction to decode/immGen; NOP_INST when if_valid=0.

Behaviour:
- Reset values: pc=RESET_PC; state=FETCH; if_valid=0; if_pc=0; if_pc_plus4=4; if_instr=NOP_INST; skid buffer empty.
- ic_read, ic_addr are combinational from state: FETCH -> ic_read=1, ic_addr=pc; KILL -> ic_read=1, ic_addr=kill_addr; HOLD -> ic_read=0, ic_addr=pc.
- Define "done" as ic_read & ~ic_stall.
- Define "accept" as ~id_stall | ~if_valid.
- Latency: with ic_stall=0 and no stalls, one instruction per cycle. The instruction fetched in cycle N appears in IF/ID in cycle N+1.

FETCH state:
- redirect_valid & ~done: pc<=redirect_pc, kill_addr<=pc, go KILL. IF/ID flushed.
- redirect_valid & done: data discarded, pc<=redirect_pc, stay FETCH. IF/ID flushed.
- done & accept: IF/ID<=(pc, pc+4, ic_rdata, valid=1), pc<=pc+4.
- done & ~accept: skid<=(pc, ic_rdata), pc<=pc+4, go HOLD. IF/ID unchanged.
- ~done & accept: IF/ID<=bubble (valid=0, instr=NOP_INST).

HOLD state:
- redirect_valid: skid dropped, pc<=redirect_pc, IF/ID flushed, go FETCH.
- ~id_stall: IF/ID<=skid (valid=1), go FETCH.
- otherwise: hold.

KILL state:
- Request at kill_addr must finish because address stability is required; returned data is always discarded.
- redirect_valid: pc<=redirect_pc, the newest redirect wins.
- done: go FETCH.
- IF/ID stays bubble while in KILL.

Priority and boundary cases:
- Redirect overrides id_stall; a flush writes a bubble even while stalled.
- PC wraps modulo 2^XLEN (0xFFFF_FFFC+4 = 0).
- Reset asserted mid-request drops the request immediately, with no handshake completion.
- if_pc_plus4 is registered alongside if_pc, never recomputed downstream.

Decomposition:
- Shared package core_pkg holds: XLEN, RESET_PC, NOP_INST, and the fetch_state enum {FETCH, HOLD, KILL}, 2-bit encoding.
- One natural sub-module, if_id_reg, holds the IF/ID pipeline register with load, hold and flush controls. The FSM, PC and skid buffer stay in inst_fetch.

Test Plan:
1. Reset with ic_stall=0, no stalls, memory returns addr-tagged words -> ic_addr 0,4,8,12 on consecutive cycles; if_pc 0,4,8 one cycle later; if_pc_plus4 4,8,12.
2. ic_stall high 3 cycles at pc=0x10 -> ic_addr held at 0x10 for 4 cycles; if_valid=0, if_instr=0x00000013 meanwhile; then if_pc=0x10.
3. id_stall high 2 cycles while if_pc=0x20 -> 0x24 goes to skid, ic_read=0 in HOLD; after release if_pc=0x24 then 0x28; no fetch duplicated or lost.
4. redirect_valid to 0x100 while ic_stall=1 on 0x30 -> ic_addr stays 0x30 until done; that data is never in IF/ID; next ic_addr=0x100.
5. redirect to 0x200 in a done cycle with id_stall=1 -> if_valid=0 next cycle; next fetch at 0x200.
6. Assert rst while state=KILL -> next cycle ic_addr=RESET_PC, if_valid=0, state FETCH.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and fetch-state encoding
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Flush wins over load; a bubble keeps the old PC fields since they are dead.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INST;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = load_pc;
      pc_plus4_d = load_pc + INST_BYTES;
      instr_d    = load_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= INST_BYTES;
      instr_q    <= NOP_INST;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign valid    = valid_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
  assign instr    = instr_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32 instruction fetch: PC, I-cache handshake, skid buffer
module inst_fetch
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  output logic            ic_read,
  output logic [XLEN-1:0] ic_addr,
  input  logic            ic_stall,
  input  logic [XLEN-1:0] ic_rdata,
  input  logic            id_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] kill_addr_q, kill_addr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;

  logic            done;
  logic            accept;
  logic [XLEN-1:0] target_pc;
  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;

  always_comb begin
    ic_read = 1'b1;
    ic_addr = pc_q;
    unique case (state_q)
      FETCH:   ic_addr = pc_q;
      KILL:    ic_addr = kill_addr_q;
      HOLD:    ic_read = 1'b0;
      default: ic_read = 1'b0;
    endcase
  end

  assign done      = ic_read & ~ic_stall;
  assign accept    = ~id_stall | ~if_valid;
  assign target_pc = word_align(redirect_pc);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_pc      = pc_q;
    ifid_instr   = ic_rdata;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d       = target_pc;
          ifid_flush = 1'b1;
          // The cache still owns an in-flight request at this address.
          if (!done) begin
            kill_addr_d = pc_q;
            state_d     = KILL;
          end
        end else if (done && accept) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + INST_BYTES;
        end else if (done) begin
          skid_pc_d    = pc_q;
          skid_instr_d = ic_rdata;
          pc_d         = pc_q + INST_BYTES;
          state_d      = HOLD;
        end else if (accept) begin
          ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d       = target_pc;
          ifid_flush = 1'b1;
          state_d    = FETCH;
        end else if (!id_stall) begin
          ifid_load  = 1'b1;
          ifid_pc    = skid_pc_q;
          ifid_instr = skid_instr_q;
          state_d    = FETCH;
        end
      end

      KILL: begin
        ifid_flush = 1'b1;
        if (redirect_valid) pc_d = target_pc;
        if (done) state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      kill_addr_q  <= RESET_PC;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .load_pc    (ifid_pc),
    .load_instr (ifid_instr),
    .valid      (if_valid),
    .pc         (if_pc),
    .pc_plus4   (if_pc_plus4),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_read;
  logic [31:0] ic_addr;
  logic        ic_stall = 1'b0;
  logic [31:0] ic_rdata;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  int total = 0;
  int bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .ic_read        (ic_read),
    .ic_addr        (ic_addr),
    .ic_stall       (ic_stall),
    .ic_rdata       (ic_rdata),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory returns an address-tagged word on completion, garbage otherwise.
  assign ic_rdata = ic_stall ? 32'hDEAD_BEEF : tag(ic_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending-discard flag, one-slot parked instruction, and the IF/ID contents.
  logic [31:0] m_pc, m_kaddr, m_hpc, m_hinstr, m_ipc, m_instr;
  bit          m_kill, m_hold, m_v;
  logic        m_done, m_accept;
  logic [31:0] m_rpc;

  assign m_done   = !m_hold && !ic_stall;
  assign m_accept = !id_stall || !m_v;
  assign m_rpc    = {redirect_pc[31:2], 2'b00};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_kill <= 1'b0; m_kaddr <= 32'h0; m_hold <= 1'b0;
      m_hpc <= 32'h0; m_hinstr <= NOP; m_v <= 1'b0; m_ipc <= 32'h0; m_instr <= NOP;
    end else if (m_kill) begin
      if (redirect_valid) m_pc <= m_rpc;
      if (m_done) m_kill <= 1'b0;
    end else if (m_hold) begin
      if (redirect_valid) begin
        m_hold <= 1'b0; m_pc <= m_rpc; m_v <= 1'b0;
      end else if (!id_stall) begin
        m_hold <= 1'b0; m_v <= 1'b1; m_ipc <= m_hpc; m_instr <= m_hinstr;
      end
    end else if (redirect_valid) begin
      m_pc <= m_rpc; m_v <= 1'b0;
      if (!m_done) begin
        m_kill <= 1'b1; m_kaddr <= m_pc;
      end
    end else if (m_done && m_accept) begin
      m_v <= 1'b1; m_ipc <= m_pc; m_instr <= tag(m_pc); m_pc <= m_pc + 32'd4;
    end else if (m_done) begin
      m_hold <= 1'b1; m_hpc <= m_pc; m_hinstr <= tag(m_pc); m_pc <= m_pc + 32'd4;
    end else if (m_accept) begin
      m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("ic_read", {31'b0, ic_read}, {31'b0, !m_hold});
      if (!m_hold) check("ic_addr", ic_addr, m_kill ? m_kaddr : m_pc);
      check("if_valid", {31'b0, if_valid}, {31'b0, m_v});
      check("if_instr", if_instr, m_v ? m_instr : NOP);
      if (m_v) begin
        check("if_pc", if_pc, m_ipc);
        check("if_pc_plus4", if_pc_plus4, m_ipc + 32'd4);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit_ifid(input string name, input logic [31:0] pc);
    check({name, "_valid"}, {31'b0, if_valid}, 32'd1);
    check({name, "_pc"}, if_pc, pc);
    check({name, "_pc4"}, if_pc_plus4, pc + 32'd4);
    check({name, "_instr"}, if_instr, tag(pc));
  endtask

  task automatic lit_bubble(input string name);
    check({name, "_valid"}, {31'b0, if_valid}, 32'd0);
    check({name, "_instr"}, if_instr, NOP);
  endtask

  initial begin
    #1 rst = 1'b1;
    checking = 1'b1;
    step(2);
    lit_bubble("rst");
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc_plus4, 32'h4);
    check("rst_addr", ic_addr, 32'h0);
    rst = 1'b0;

    // Streaming fetch.
    check("s_addr0", ic_addr, 32'h0);
    step(1); check("s_addr4", ic_addr, 32'h4); lit_ifid("s0", 32'h0);
    step(1); check("s_addr8", ic_addr, 32'h8); lit_ifid("s4", 32'h4);
    step(1); check("s_addrC", ic_addr, 32'hC); lit_ifid("s8", 32'h8);
    step(1);

    // Cache stall for three cycles at 0x10.
    ic_stall = 1'b1;
    check("cs_addr0", ic_addr, 32'h10);
    step(1); check("cs_addr1", ic_addr, 32'h10); lit_bubble("cs1");
    step(1); check("cs_addr2", ic_addr, 32'h10);
    step(1); ic_stall = 1'b0; check("cs_addr3", ic_addr, 32'h10); lit_bubble("cs3");
    step(1); lit_ifid("cs_out", 32'h10);

    // Decode stall pushes 0x24 into the skid buffer.
    step(4); lit_ifid("ds_pre", 32'h20); check("ds_addr", ic_addr, 32'h24);
    id_stall = 1'b1;
    step(1); check("ds_read1", {31'b0, ic_read}, 32'd0); lit_ifid("ds_hold1", 32'h20);
    step(1); id_stall = 1'b0; check("ds_read2", {31'b0, ic_read}, 32'd0);
    step(1); lit_ifid("ds_skid", 32'h24); check("ds_addr2", ic_addr, 32'h28);
    step(1); lit_ifid("ds_next", 32'h28);
    step(1);

    // Redirect while the request at 0x30 is stalled.
    check("rk_addr0", ic_addr, 32'h30);
    ic_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(1); redirect_valid = 1'b0; check("rk_addr1", ic_addr, 32'h30); lit_bubble("rk1");
    step(1); ic_stall = 1'b0; check("rk_addr2", ic_addr, 32'h30);
    step(1); check("rk_addr3", ic_addr, 32'h100); lit_bubble("rk3");
    step(1); lit_ifid("rk_out", 32'h100);

    // Redirect in a completing cycle with decode stalled.
    id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(1); id_stall = 1'b0; redirect_valid = 1'b0;
    lit_bubble("rd"); check("rd_addr", ic_addr, 32'h200);
    step(1); lit_ifid("rd_out", 32'h200);

    // Second redirect in KILL wins; unaligned target and PC wrap.
    ic_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    step(1); ic_stall = 1'b0; redirect_pc = 32'hFFFF_FFFF;
    check("nw_addr", ic_addr, 32'h204);
    step(1); redirect_valid = 1'b0; check("nw_tgt", ic_addr, 32'hFFFF_FFFC);
    step(1); lit_ifid("wrap", 32'hFFFF_FFFC); check("wrap_pc4", if_pc_plus4, 32'h0);
    check("wrap_addr", ic_addr, 32'h0);
    step(1); lit_ifid("wrap0", 32'h0);

    // Reset asserted while in KILL.
    ic_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(1); redirect_valid = 1'b0; check("rr_kill", ic_addr, 32'h4);
    #2 rst = 1'b1;
    #1 check("rr_addr", ic_addr, 32'h0); lit_bubble("rr");
    check("rr_read", {31'b0, ic_read}, 32'd1);
    step(1); rst = 1'b0; ic_stall = 1'b0;
    step(1); lit_ifid("rr_out", 32'h0); check("rr_addr4", ic_addr, 32'h4);
    step(3);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
